tile_board_writer: RTL and testbench

Write-side companion to the VGA tile renderer. Accepts cell-update commands from game logic into a 16-entry staging copy of the 4x4 tile board (5-bit tile IDs). Commits only the changed cells into the shadow RAM during vertical sync, so the renderer never scans out a half-updated board. Sits between the game controller and the shadow RAM write port; the renderer owns the read port.

---
 rtl/tile_board_writer.sv | 165 ++++++++++++++++
 tb/tb_tile_board_writer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_board_writer.sv
// Staging buffer for the 4x4 tile board; commits only changed cells to the shadow RAM during vsync.
// Optional build macro TBW_RANGE_CHECK_EN rejects tile IDs above MAX_TILE and pulses cmd_err.
module tile_board_writer #(
    parameter int unsigned MAX_TILE = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_op,
    input  logic [3:0] cmd_addr,
    input  logic [4:0] cmd_data,
    output logic       cmd_err,
    input  logic       vga_vs,
    output logic       shadow_ram_we,
    output logic [3:0] shadow_ram_waddr,
    output logic [4:0] shadow_ram_wdata,
    output logic       pending,
    output logic       frame_done
);

    localparam int unsigned CELLS = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned TW    = 5;

`ifdef TBW_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [TW-1:0]     stage [CELLS];
    logic [CELLS-1:0]  dirty;
    logic [CELLS-1:0]  dirty_acc;
    logic [AW-1:0]     idx;
    logic              vs_q;
    logic              vs_fall;
    logic              accept;
    logic              data_bad;
    logic              reject;
    logic              store;

    logic              we_nxt;
    logic [AW-1:0]     waddr_nxt;
    logic [TW-1:0]     wdata_nxt;
    logic              done_nxt;
    logic              err_nxt;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign vs_fall   = vs_q && !vga_vs;
    assign data_bad  = cmd_data > TW'(MAX_TILE);
    assign reject    = RANGE_CHECK && data_bad;
    assign store     = accept && !reject;
    assign pending   = |dirty;

    // Dirty mask including a command accepted this cycle, so it joins a pass starting now.
    always_comb begin
        dirty_acc = dirty;
        if (store) begin
            if (cmd_op) begin
                dirty_acc = '1;
            end else begin
                dirty_acc[cmd_addr] = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (vs_fall && (dirty_acc != '0)) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                if (idx == AW'(CELLS - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered write port and pulses
    always_comb begin
        we_nxt    = 1'b0;
        waddr_nxt = shadow_ram_waddr;
        wdata_nxt = shadow_ram_wdata;
        done_nxt  = 1'b0;
        err_nxt   = accept && reject;
        case (state)
            COMMIT: begin
                we_nxt    = dirty[idx];
                waddr_nxt = idx;
                wdata_nxt = stage[idx];
            end
            DONE:    done_nxt = 1'b1;
            default: ;
        endcase
    end

    // Staging, dirty tracking, scan index and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage            <= '{default: '0};
            dirty            <= '0;
            idx              <= '0;
            vs_q             <= 1'b1;
            shadow_ram_we    <= 1'b0;
            shadow_ram_waddr <= '0;
            shadow_ram_wdata <= '0;
            frame_done       <= 1'b0;
            cmd_err          <= 1'b0;
        end else begin
            vs_q             <= vga_vs;
            shadow_ram_we    <= we_nxt;
            shadow_ram_waddr <= waddr_nxt;
            shadow_ram_wdata <= wdata_nxt;
            frame_done       <= done_nxt;
            cmd_err          <= err_nxt;

            if (store) begin
                if (cmd_op) begin
                    stage <= '{default: cmd_data};
                end else begin
                    stage[cmd_addr] <= cmd_data;
                end
            end

            case (state)
                IDLE: begin
                    dirty <= dirty_acc;
                    idx   <= '0;
                end
                COMMIT: begin
                    dirty[idx] <= 1'b0;
                    idx        <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_board_writer.sv
// Directed bench for tile_board_writer: model-driven scoreboard of expected RAM writes and frame_done cycles.
module tb_tile_board_writer;

    localparam int unsigned MAX_TILE = 12;
`ifdef TBW_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    typedef struct {
        logic [3:0] addr;
        logic [4:0] data;
        int         cyc;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [3:0] cmd_addr;
    logic [4:0] cmd_data;
    logic       cmd_err;
    logic       vga_vs;
    logic       shadow_ram_we;
    logic [3:0] shadow_ram_waddr;
    logic [4:0] shadow_ram_wdata;
    logic       pending;
    logic       frame_done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int e0    = 0;

    wr_t        exp_q[$];
    int         done_q[$];
    wr_t        mon_e;
    int         mon_d;
    logic [4:0] m_stage [16];
    logic [15:0] m_dirty;

    tile_board_writer #(.MAX_TILE(MAX_TILE)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_addr         (cmd_addr),
        .cmd_data         (cmd_data),
        .cmd_err          (cmd_err),
        .vga_vs           (vga_vs),
        .shadow_ram_we    (shadow_ram_we),
        .shadow_ram_waddr (shadow_ram_waddr),
        .shadow_ram_wdata (shadow_ram_wdata),
        .pending          (pending),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every write and frame_done must match the next expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (shadow_ram_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_we", 32'(shadow_ram_we), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("we_addr", 32'(shadow_ram_waddr), 32'(mon_e.addr));
                    check("we_data", 32'(shadow_ram_wdata), 32'(mon_e.data));
                    check("we_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end
            if (frame_done === 1'b1) begin
                if (done_q.size() == 0) begin
                    check("spurious_done", 32'(frame_done), 32'd0);
                end else begin
                    mon_d = done_q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(mon_d));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_apply(input logic op, input logic [3:0] addr, input logic [4:0] data);
        if (op) begin
            m_stage = '{default: data};
            m_dirty = '1;
        end else begin
            m_stage[addr] = data;
            m_dirty[addr] = 1'b1;
        end
    endtask

    task automatic send(input logic op, input logic [3:0] addr, input logic [4:0] data);
        int   n = 0;
        logic bad;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        while (cmd_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        bad = RANGE_CHECK && (data > 5'(MAX_TILE));
        if (!bad) model_apply(op, addr, data);
        check("cmd_err", 32'(cmd_err), 32'(bad));
        check("pending_after_cmd", 32'(pending), 32'(m_dirty != 16'd0));
    endtask

    // Falling vsync: the next posedge is E0; expectations are pushed from the model
    task automatic drop_vs();
        wr_t        w;
        logic [3:0] a;
        @(negedge clk);
        vga_vs = 1'b0;
        e0 = cyc + 1;
        for (int k = 0; k < 16; k++) begin
            a = 4'(k);
            if (m_dirty[a]) begin
                w.addr = a;
                w.data = m_stage[a];
                w.cyc  = e0 + 1 + k;
                exp_q.push_back(w);
            end
        end
        if (m_dirty != 16'd0) done_q.push_back(e0 + 17);
        m_dirty = '0;
    endtask

    task automatic raise_vs();
        @(negedge clk);
        vga_vs = 1'b1;
    endtask

    task automatic frame();
        drop_vs();
        step(24);
        check("writes_left", 32'(exp_q.size()), 32'd0);
        check("done_left", 32'(done_q.size()), 32'd0);
        check("pending_after_pass", 32'(pending), 32'd0);
        raise_vs();
        step(2);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        vga_vs    = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        m_stage   = '{default: '0};
        m_dirty   = '0;

        #3;
        check("rst_we", 32'(shadow_ram_we), 32'd0);
        check("rst_waddr", 32'(shadow_ram_waddr), 32'd0);
        check("rst_wdata", 32'(shadow_ram_wdata), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(cmd_err), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        step(2);
        rst_n = 1'b1;
        step(2);
        check("idle_ready", 32'(cmd_ready), 32'd1);

        // Two empty frames: no writes, no frame_done
        frame();
        frame();

        // Sparse update of cells 5 and 10
        send(1'b0, 4'd5, 5'd7);
        send(1'b0, 4'd10, 5'd3);
        frame();

        // Overwrite before vsync: last value wins, single write
        send(1'b0, 4'd2, 5'd4);
        send(1'b0, 4'd2, 5'd9);
        frame();

        // Fill, with a command held across the whole pass
        send(1'b1, 4'd0, 5'd11);
        drop_vs();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_addr  = 4'd3;
        cmd_data  = 5'd1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("ready_low_cycles", 32'(n), 32'd17);
        @(negedge clk);
        cmd_valid = 1'b0;
        model_apply(1'b0, 4'd3, 5'd1);
        check("held_cmd_pending", 32'(pending), 32'd1);
        step(2);
        check("fill_writes_left", 32'(exp_q.size()), 32'd0);
        check("fill_done_left", 32'(done_q.size()), 32'd0);
        raise_vs();
        step(2);

        // Reset in the middle of a fill pass
        send(1'b1, 4'd0, 5'd11);
        drop_vs();
        while (cyc < e0 + 6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        check("writes_before_reset", 32'(exp_q.size()), 32'd10);
        exp_q.delete();
        done_q.delete();
        m_dirty = '0;
        m_stage = '{default: '0};
        #1;
        check("midrst_we", 32'(shadow_ram_we), 32'd0);
        check("midrst_pending", 32'(pending), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        check("midrst_done", 32'(frame_done), 32'd0);
        step(2);
        vga_vs = 1'b1;
        step(1);
        rst_n = 1'b1;
        step(2);
        frame();

        // Out-of-range tile ID (rejected only with range check enabled)
        send(1'b0, 4'd0, 5'd13);
        step(1);
        check("cmd_err_pulse_end", 32'(cmd_err), 32'd0);
        frame();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
